// File: rtl/lsu_mem_ctrl_if.sv
// rtl/lsu_mem_ctrl_if.sv - request/response and PMEM port bundle for lsu_mem_ctrl
interface lsu_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_valid;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_wen;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_size, req_unsigned,
               resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_valid, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_size, req_unsigned,
               resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_valid, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store sequencer between execute stage and PMEM
// One request in flight; PMEM request held LATENCY cycles, then a registered response.
module lsu_mem_ctrl #(
    parameter int LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
    lsu_mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [1:0]  a_lo;
    logic [1:0]  sz;
    logic        uns;
    logic        is_store;

    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        rerr;
    logic        mv;
    logic        mwen;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [7:0]  mwmask;

    logic        req_err;
    logic [3:0]  lane_mask;
    logic [31:0] shifted;
    logic [31:0] ld_data;

    always_comb begin
        req_err = (bus.req_size == 2'd3)
               || (bus.req_size == 2'd1 && bus.req_addr[0])
               || (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00);
        case (bus.req_size)
            2'd0:    lane_mask = 4'b0001 << bus.req_addr[1:0];
            2'd1:    lane_mask = 4'b0011 << bus.req_addr[1:0];
            default: lane_mask = 4'b1111;
        endcase
    end

    // Load lane extraction uses the latched address/size, not the live request inputs.
    always_comb begin
        shifted = bus.mem_rdata >> {a_lo, 3'b000};
        ld_data = shifted;
        case (sz)
            2'd0:    ld_data = uns ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    ld_data = uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            a_lo     <= 2'd0;
            sz       <= 2'd0;
            uns      <= 1'b0;
            is_store <= 1'b0;
            rdy      <= 1'b0;
            rv       <= 1'b0;
            rdata    <= 32'd0;
            rerr     <= 1'b0;
            mv       <= 1'b0;
            mwen     <= 1'b0;
            maddr    <= 32'd0;
            mwdata   <= 32'd0;
            mwmask   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    rdy <= 1'b1;
                    if (bus.req_valid && rdy) begin
                        rdy      <= 1'b0;
                        a_lo     <= bus.req_addr[1:0];
                        sz       <= bus.req_size;
                        uns      <= bus.req_unsigned;
                        is_store <= bus.req_wen;
                        if (req_err) begin
                            state <= RESP;
                            rv    <= 1'b1;
                            rerr  <= 1'b1;
                            rdata <= 32'd0;
                        end else begin
                            state  <= ACCESS;
                            cnt    <= LAT_M1;
                            mv     <= 1'b1;
                            mwen   <= bus.req_wen;
                            maddr  <= {bus.req_addr[31:2], 2'b00};
                            mwdata <= bus.req_wdata << {bus.req_addr[1:0], 3'b000};
                            mwmask <= {4'b0000, lane_mask};
                        end
                    end
                end
                ACCESS: begin
                    // Write strobe lasts one cycle so PMEM commits the store exactly once.
                    mwen <= 1'b0;
                    if (cnt == 4'd0) begin
                        state  <= RESP;
                        mv     <= 1'b0;
                        mwmask <= 8'd0;
                        rv     <= 1'b1;
                        rerr   <= 1'b0;
                        rdata  <= is_store ? 32'd0 : ld_data;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state <= IDLE;
                        rv    <= 1'b0;
                        rdy   <= 1'b1;
                        rdata <= 32'd0;
                        rerr  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = rdy;
    assign bus.resp_valid = rv;
    assign bus.resp_rdata = rdata;
    assign bus.resp_err   = rerr;
    assign bus.mem_valid  = mv;
    assign bus.mem_wen    = mwen;
    assign bus.mem_raddr  = maddr;
    assign bus.mem_waddr  = maddr;
    assign bus.mem_wdata  = mwdata;
    assign bus.mem_wmask  = mwmask;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - scoreboard bench for lsu_mem_ctrl with byte-level memory reference
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;
    localparam int LAT = 3;
    localparam logic [31:0] BASE = 32'h8000_0000;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          vc;
        int          wc;
        int          lat;
        int          acc;
    } rexp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  wmask;
    } mexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_ctrl_if bus();
    lsu_mem_ctrl #(.LATENCY(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    rexp_t rq[$];
    mexp_t mq[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cyc = 0;
    bit hold_low = 1'b0;
    bit force_high = 1'b0;
    logic [7:0] ref_b[64];
    logic [7:0] pm_b[64];

    logic [31:0] last_rdata = 32'd0;
    logic        last_err = 1'b0;
    int          last_vc = 0;
    int          last_wc = 0;
    logic [31:0] cap_addr = 32'd0;
    logic [31:0] cap_wdata = 32'd0;
    logic [7:0]  cap_mask = 8'd0;

    int          vcnt = 0;
    int          wcnt = 0;
    logic        prev_mv = 1'b0;
    logic        prev_rv = 1'b0;
    logic [31:0] held_rdata = 32'd0;
    logic        held_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #2;
        bus.resp_ready = hold_low ? 1'b0 : (force_high ? 1'b1 : ($urandom_range(0, 3) != 0));
    end

    // Physical memory: commits masked writes, returns the addressed word while mem_valid.
    always @(negedge clk) begin
        if (bus.mem_valid && bus.mem_wen) begin
            for (int i = 0; i < 4; i++)
                if (bus.mem_wmask[i]) pm_b[int'(bus.mem_waddr[5:0]) + i] = bus.mem_wdata[8*i +: 8];
        end
        if (bus.mem_valid) begin
            int b;
            b = int'(bus.mem_raddr[5:2]) * 4;
            bus.mem_rdata = {pm_b[b+3], pm_b[b+2], pm_b[b+1], pm_b[b]};
        end else begin
            bus.mem_rdata = $urandom;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            vcnt = 0;
            wcnt = 0;
            prev_mv = 1'b0;
            prev_rv = 1'b0;
        end else begin
            if (bus.mem_valid) begin
                if (!prev_mv) begin
                    cap_addr  = bus.mem_waddr;
                    cap_wdata = bus.mem_wdata;
                    cap_mask  = bus.mem_wmask;
                    if (mq.size() == 0) begin
                        chk("unexpected_mem_access", 32'd1, 32'd0);
                    end else begin
                        mexp_t m;
                        m = mq.pop_front();
                        chk("mem_waddr", bus.mem_waddr, m.addr);
                        chk("mem_raddr", bus.mem_raddr, m.addr);
                        chk("mem_wdata", bus.mem_wdata, m.wdata);
                        chk("mem_wmask", {24'd0, bus.mem_wmask}, {24'd0, m.wmask});
                    end
                end
                vcnt++;
                if (bus.mem_wen) wcnt++;
                chk("access_req_ready", {31'd0, bus.req_ready}, 32'd0);
            end else begin
                chk("idle_mem_strobes", {23'd0, bus.mem_wen, bus.mem_wmask}, 32'd0);
            end
            if (bus.resp_valid) begin
                chk("resp_req_ready", {31'd0, bus.req_ready}, 32'd0);
                if (!prev_rv) begin
                    held_rdata = bus.resp_rdata;
                    held_err   = bus.resp_err;
                    if (rq.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
                    else chk("resp_latency", cyc - rq[0].acc, rq[0].lat);
                end else begin
                    chk("resp_stable_rdata", bus.resp_rdata, held_rdata);
                    chk("resp_stable_err", {31'd0, bus.resp_err}, {31'd0, held_err});
                end
                if (bus.resp_ready && rq.size() != 0) begin
                    rexp_t r;
                    r = rq.pop_front();
                    chk("resp_rdata", bus.resp_rdata, r.rdata);
                    chk("resp_err", {31'd0, bus.resp_err}, {31'd0, r.err});
                    chk("mem_valid_cycles", vcnt, r.vc);
                    chk("mem_wen_cycles", wcnt, r.wc);
                    last_rdata = bus.resp_rdata;
                    last_err   = bus.resp_err;
                    last_vc    = vcnt;
                    last_wc    = wcnt;
                    hs_cyc     = cyc;
                    vcnt = 0;
                    wcnt = 0;
                end
            end
            prev_mv = bus.mem_valid;
            prev_rv = bus.resp_valid && !bus.resp_ready;
        end
    end

    task automatic issue(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, output int acc);
        rexp_t r;
        mexp_t m;
        logic err;
        int nb;
        int off;
        logic [31:0] v;
        bus.req_addr     = addr;
        bus.req_wen      = wen;
        bus.req_wdata    = wdata;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_valid    = 1'b1;
        acc = -1;
        for (int t = 0; t < 300; t++) begin
            if (bus.req_ready) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            chk("accept_timeout", 32'd1, 32'd0);
            bus.req_valid = 1'b0;
            return;
        end
        err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
        nb = 1 << size;
        off = int'(addr[5:0]);
        v = 32'd0;
        m.wmask = 8'd0;
        if (!err) begin
            for (int i = 0; i < nb; i++) begin
                if (wen) ref_b[off+i] = wdata[8*i +: 8];
                else v = v | (32'(ref_b[off+i]) << (8*i));
                m.wmask[int'(addr[1:0]) + i] = 1'b1;
            end
            if (!wen && !uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
            m.addr  = {addr[31:2], 2'b00};
            m.wdata = wdata << (8*addr[1:0]);
            mq.push_back(m);
        end
        r.rdata = (err || wen) ? 32'd0 : v;
        r.err   = err;
        r.vc    = err ? 0 : LAT;
        r.wc    = (!err && wen) ? 1 : 0;
        r.lat   = err ? 1 : LAT + 1;
        r.acc   = acc;
        rq.push_back(r);
        @(negedge clk);
        bus.req_valid    = 1'b0;
        bus.req_addr     = $urandom;
        bus.req_wen      = 1'($urandom);
        bus.req_wdata    = $urandom;
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
    endtask

    task automatic drain();
        for (int t = 0; t < 400 && rq.size() != 0; t++) @(negedge clk);
        chk("drain_timeout", rq.size(), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int a;
        logic [5:0] off;
        logic [1:0] sz;
        bus.req_valid = 1'b0;
        bus.req_addr = 32'd0;
        bus.req_wen = 1'b0;
        bus.req_wdata = 32'd0;
        bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.resp_ready = 1'b0;
        bus.mem_rdata = 32'd0;
        for (int i = 0; i < 64; i++) begin
            ref_b[i] = 8'($urandom);
            pm_b[i]  = ref_b[i];
        end

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
        chk("rst_mem_wmask_wen", {23'd0, bus.mem_wen, bus.mem_wmask}, 32'd0);
        chk("rst_mem_addr_data", bus.mem_raddr | bus.mem_waddr | bus.mem_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, bus.req_ready}, 32'd1);

        {ref_b[3], ref_b[2], ref_b[1], ref_b[0]} = 32'h11F2_3344;
        {pm_b[3], pm_b[2], pm_b[1], pm_b[0]}     = 32'h11F2_3344;
        issue(BASE + 32'd2, 1'b0, $urandom, 2'd0, 1'b0, a);
        drain();
        chk("byte_load_signed", last_rdata, 32'hFFFF_FFF2);
        chk("byte_load_err", {31'd0, last_err}, 32'd0);

        issue(BASE + 32'd6, 1'b1, 32'h0000_BEEF, 2'd1, 1'b0, a);
        drain();
        chk("half_store_waddr", cap_addr, 32'h8000_0004);
        chk("half_store_wdata", cap_wdata, 32'hBEEF_0000);
        chk("half_store_wmask", {24'd0, cap_mask}, 32'h0000_000C);
        chk("half_store_wen_cycles", last_wc, 32'd1);
        chk("half_store_valid_cycles", last_vc, LAT);
        chk("half_store_rdata", last_rdata, 32'd0);
        chk("half_store_pmem", {24'd0, pm_b[7]}, 32'h0000_00BE);

        issue(BASE + 32'd1, 1'b0, 32'd0, 2'd2, 1'b0, a);
        drain();
        chk("misaligned_err", {31'd0, last_err}, 32'd1);
        chk("misaligned_rdata", last_rdata, 32'd0);
        chk("misaligned_no_access", last_vc, 32'd0);

        ref_b[16] = 8'h01; ref_b[17] = 8'h80;
        pm_b[16]  = 8'h01; pm_b[17]  = 8'h80;
        hold_low = 1'b1;
        issue(BASE + 32'd16, 1'b0, 32'd0, 2'd1, 1'b1, a);
        for (int t = 0; t < 50 && !bus.resp_valid; t++) @(negedge clk);
        chk("bp_resp_seen", {31'd0, bus.resp_valid}, 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
            chk("bp_resp_rdata", bus.resp_rdata, 32'h0000_8001);
            chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        force_high = 1'b1;
        hold_low = 1'b0;
        issue(BASE + 32'd20, 1'b0, 32'd0, 2'd2, 1'b1, a);
        chk("bp_next_accept", a, hs_cyc + 1);
        drain();
        force_high = 1'b0;

        repeat (60) begin
            sz  = 2'($urandom_range(0, 3));
            off = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) off[0] = 1'b0;
                if (sz == 2'd2) off[1:0] = 2'b00;
            end
            issue(BASE | {26'd0, off}, 1'($urandom), $urandom, sz, 1'($urandom), a);
        end
        drain();

        issue(BASE + 32'd8, 1'b0, 32'd0, 2'd2, 1'b0, a);
        @(negedge clk);
        rst = 1'b1;
        rq.delete();
        mq.delete();
        @(negedge clk);
        chk("midrst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
        chk("midrst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("midrst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready_after", {31'd0, bus.req_ready}, 32'd1);
        repeat (10) begin
            @(negedge clk);
            chk("midrst_no_stale_resp", {31'd0, bus.resp_valid}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store sequencer between the execute stage and the `PMEM` physical-memory port. It accepts one load or store request at a time over a valid/ready handshake. It converts the byte address and size into a word-aligned PMEM access with a byte write mask and lane-shifted write data. It holds the PMEM request for a fixed number of cycles, then returns sign- or zero-extended load data over a second valid/ready handshake.

## Interface
- `LATENCY`, default 1: number of cycles `mem_valid` is held per access; legal range 1..15.

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_addr` in 32: byte address.
- `req_wen` in 1: 1 = store, 0 = load.
- `req_wdata` in 32: store data, right-aligned.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = reserved.
- `req_unsigned` in 1: 1 = zero-extend load, 0 = sign-extend.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: the access was misaligned or used a reserved size.
- `mem_valid` out 1: PMEM request.
- `mem_raddr` out 32: PMEM read address.
- `mem_rdata` in 32: PMEM read data.
- `mem_wen` out 1: PMEM write enable.
- `mem_waddr` out 32: PMEM write address.
- `mem_wdata` out 32: PMEM write data.
- `mem_wmask` out 8: PMEM write byte mask; bits [7:4] are always 0.

## Operation
- **States**
  - IDLE: `req_ready` = 1.
  - ACCESS: `mem_valid` = 1; a 4-bit counter runs.
  - RESP: `resp_valid` = 1.
- **Accepting a request**
  - A request is accepted on an edge where `req_valid & req_ready`.
  - All `req_*` fields are latched at acceptance; later changes to the inputs are ignored.
- **Error check at acceptance**
  - An error is any of: `req_size` = 3; half access with `addr[0]` = 1; word access with `addr[1:0]` ≠ 0.
  - IDLE -> RESP directly, with `resp_err` = 1 and `resp_rdata` = 0.
  - No PMEM access is made for an errored request.
- **Good request at acceptance**
  - IDLE -> ACCESS, with the counter loaded to `LATENCY` - 1.
- **ACCESS outputs**
  - `mem_raddr` = `mem_waddr` = `{addr[31:2], 2'b00}`.
  - `mem_wdata` = `wdata << (8*addr[1:0])`.
  - `mem_wmask` = `4'b0001 << addr[1:0]` for byte, `4'b0011 << addr[1:0]` for half, `4'b1111` for word; upper nibble 0.
  - `mem_wen` = store flag, asserted in the first ACCESS cycle only, so PMEM performs exactly one write.
- **ACCESS progress**
  - The counter decrements each cycle.
  - In the cycle the counter is 0, `mem_rdata` is sampled: shifted right by `8*addr[1:0]`, masked to the access size, then extended per `req_unsigned`.
  - State then moves ACCESS -> RESP.
  - For stores, the stored response data is 0.
- **RESP**
  - `resp_valid` = 1 and the response is held stable until `resp_ready`.
  - RESP -> IDLE on `resp_valid & resp_ready`.
- **Outside ACCESS**
  - `mem_valid` = 0 and `mem_wen` = 0.
  - `mem_wmask` = 0; address and data outputs are don't-care but must not be X.
- **Reset**
  - Reset forces IDLE.
  - Every output is 0 while `rst` is high, including `req_ready`.
  - `req_ready` = 1 in the first cycle after `rst` falls.
- **Reset during ACCESS or RESP**
  - The transaction is abandoned and no response is produced.
  - A write already presented to PMEM is not undone.

## Timing
- **Latency**
  - Request accepted at edge N.
  - ACCESS occupies cycles N+1 .. N+`LATENCY`.
  - `resp_valid` rises at cycle N+`LATENCY`+1.
  - Error requests: `resp_valid` rises at cycle N+1.
- **Throughput**
  - With `resp_ready` held at 1: one access per `LATENCY`+2 cycles.
  - The next acceptance is possible in the cycle after the response handshake.
- **Overlap**
  - `req_ready` is 0 in ACCESS and RESP; there is no overlap of requests.
- **`resp_ready` behaviour**
  - `resp_ready` held low stalls in RESP indefinitely with the outputs constant.
  - `resp_ready` already high when RESP is entered completes the handshake in that first RESP cycle.
- **Valid without ready**
  - `req_valid` asserted while `req_ready` = 0 is not accepted.
  - The request must be held by the source until accepted.

## Test plan
- **Byte load, sign-extended:** `LATENCY`=1, PMEM word at 0x80000000 = 0x11F2_3344, load byte signed at 0x80000002.
  - `mem_raddr` = 0x80000000 for 1 cycle.
  - Response 0xFFFF_FFF2, `resp_err` = 0, `resp_valid` at N+2.
- **Half store:** `LATENCY`=3, store half 0xBEEF at 0x80000006.
  - `mem_waddr` = 0x80000004, `mem_wdata` = 0xBEEF_0000, `mem_wmask` = 0x0C.
  - `mem_wen` high for exactly 1 cycle, `mem_valid` high for 3 cycles.
  - Response `resp_rdata` = 0.
- **Misaligned word:** load word at 0x80000001.
  - `mem_valid` never asserts.
  - `resp_valid` at N+1 with `resp_err` = 1 and `resp_rdata` = 0.
- **Back-pressure:** hold `resp_ready` = 0 for 5 cycles after an unsigned half load of 0x8001.
  - `resp_valid` and `resp_rdata` = 0x0000_8001 stay stable.
  - `req_ready` = 0 throughout.
  - The next request is accepted in the cycle after `resp_ready` rises.
- **Reset mid-access:** `LATENCY`=4, assert `rst` in the 2nd ACCESS cycle.
  - Next cycle: `mem_valid` = 0, `resp_valid` = 0, `req_ready` = 0.
  - After `rst` drops: `req_ready` = 1 and no stale response appears.
